// File: rtl/tile_renderer.sv
// tile_renderer: three-stage pixel pipeline that turns the VGA raster position
// into a board RAM lookup, drives the glyph ROM interface and produces a
// registered RGB colour. One pixel per clock, fixed 3-clock latency.
module tile_renderer #(
    parameter int BOARD_X0 = 192,
    parameter int BOARD_Y0 = 112
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank_n,
    input  logic       vs,
    input  logic       game_over,
    input  logic [3:0] boom_x,
    input  logic [3:0] boom_y,
    input  logic [3:0] cursor_x,
    input  logic [3:0] cursor_y,
    output logic [7:0] cell_addr,
    input  logic [7:0] cell_data,
    output logic [2:0] indexx,
    output logic [2:0] indexy,
    output logic [2:0] number,
    output logic       flag,
    output logic       mine,
    output logic       dead,
    input  logic       pixel,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue
);

    localparam logic [23:0] COL_BLACK  = 24'h000000;
    localparam logic [23:0] COL_BORDER = 24'h404040;
    localparam logic [23:0] COL_CURSOR = 24'hFFFF00;
    localparam logic [23:0] COL_RED    = 24'hFF0000;
    localparam logic [23:0] COL_BLUE   = 24'h0000FF;
    localparam logic [23:0] COL_HIDDEN = 24'hC0C0C0;
    localparam logic [23:0] COL_OPEN   = 24'hE0E0E0;
    localparam logic [23:0] COL_BOOM   = 24'hFF4040;

    // Per-pixel context carried down the pipeline. Cursor and boom matches are
    // resolved at stage 0 so a mid-line change of those inputs stays aligned
    // with the pixel that was on DrawX/DrawY when it happened.
    typedef struct packed {
        logic       in_board;
        logic       blank;
        logic [3:0] px;         // pixel x inside the 16x16 cell
        logic [3:0] py;         // pixel y inside the 16x16 cell
        logic       is_cursor;
        logic       is_boom;
    } stage_t;

    logic [9:0]  lx, ly;
    stage_t      s0_d, s0, s1;
    logic [2:0]  c_cnt;
    logic        c_mine, c_flag, c_rev;
    logic        on_edge;
    logic [23:0] rgb_d;
    logic        vs_q, go_q;
    logic [4:0]  fcnt;
    logic        blink;
    logic        unused_bits;

    // Board-relative coordinates; 10-bit wrap makes left/above pixels huge.
    assign lx = DrawX - 10'(BOARD_X0);
    assign ly = DrawY - 10'(BOARD_Y0);

    // Stage-0 next values: board membership, local pixel, cursor/boom match
    always_comb begin
        s0_d           = '0;
        s0_d.in_board  = (lx[9:8] == 2'b00) && (ly[9:8] == 2'b00);
        s0_d.blank     = blank_n;
        s0_d.px        = lx[3:0];
        s0_d.py        = ly[3:0];
        s0_d.is_cursor = (lx[7:4] == cursor_x) && (ly[7:4] == cursor_y);
        s0_d.is_boom   = (lx[7:4] == boom_x) && (ly[7:4] == boom_y);
    end

    // Stage 0/1 registers; stage 1 lines up with the RAM read latency
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s0        <= '0;
            s1        <= '0;
            cell_addr <= '0;
        end else begin
            s0        <= s0_d;
            s1        <= s0;
            cell_addr <= {ly[7:4], lx[7:4]};
        end
    end

    assign c_cnt       = cell_data[2:0];
    assign c_mine      = cell_data[3];
    assign c_flag      = cell_data[4];
    assign c_rev       = cell_data[5];
    assign unused_bits = ^cell_data[7:6];

    // Stage-1 glyph selection; everything is forced to 0 off the board
    always_comb begin
        indexx = '0;
        indexy = '0;
        number = '0;
        flag   = 1'b0;
        mine   = 1'b0;
        dead   = 1'b0;
        if (s1.in_board) begin
            indexx = s1.px[3:1];
            indexy = s1.py[3:1];
            flag   = c_flag && !c_rev;
            mine   = c_mine && (c_rev || game_over) && !c_flag && !s1.is_boom;
            dead   = game_over && s1.is_boom;
            if (c_rev && !c_mine)
                number = c_cnt;
        end
    end

    assign on_edge = (s1.px == 4'd0) || (s1.px == 4'd15) ||
                     (s1.py == 4'd0) || (s1.py == 4'd15);
    assign blink   = fcnt[4];

    // Stage-2 colour priority: blanking, off-board, cursor, glyph, background
    always_comb begin
        rgb_d = COL_BLACK;
        if (!s1.blank)
            rgb_d = COL_BLACK;
        else if (!s1.in_board)
            rgb_d = COL_BORDER;
        else if (s1.is_cursor && on_edge && !game_over)
            rgb_d = COL_CURSOR;
        else if (pixel && flag)
            rgb_d = COL_RED;
        else if (pixel && dead)
            rgb_d = COL_RED;
        else if (pixel && mine)
            rgb_d = COL_BLACK;
        else if (pixel && (number != 3'd0))
            rgb_d = COL_BLUE;
        else if (game_over && s1.is_boom)
            rgb_d = blink ? COL_BOOM : COL_OPEN;
        else if (c_rev)
            rgb_d = COL_OPEN;
        else
            rgb_d = COL_HIDDEN;
    end

    // Stage-2 output register
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            {Red, Green, Blue} <= '0;
        else
            {Red, Green, Blue} <= rgb_d;
    end

    // Frame counter: counts vsync falling edges, restarts when the game is lost
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vs_q <= 1'b1;
            go_q <= 1'b0;
            fcnt <= '0;
        end else begin
            vs_q <= vs;
            go_q <= game_over;
            if (game_over && !go_q)
                fcnt <= '0;
            else if (vs_q && !vs)
                fcnt <= fcnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: streams pixels through tile_renderer against a board RAM
// model and a toy glyph ROM, comparing address, glyph and colour outputs with
// a reference model derived directly from the board/colour rules.
module tb_tile_renderer;
    localparam int X0   = 192;
    localparam int Y0   = 112;
    localparam int MAXN = 256;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] DrawX, DrawY;
    logic       blank_n, vs, game_over;
    logic [3:0] boom_x, boom_y, cursor_x, cursor_y;
    logic [7:0] cell_addr, cell_data;
    logic [2:0] indexx, indexy, number;
    logic       flag, mine, dead, pixel;
    logic [7:0] Red, Green, Blue;

    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  addr;
        logic [11:0] gl;   // {indexx, indexy, number, flag, mine, dead}
    } exp_t;

    logic [7:0] mem [256];
    int   nchk = 0, nfail = 0;
    int   fcnt = 0;
    bit   go = 0;

    int   sx [MAXN], sy [MAXN], scx [MAXN], scy [MAXN], sbx [MAXN], sby [MAXN];
    bit   sb [MAXN];
    exp_t ex [MAXN];
    logic [23:0] obs_rgb  [MAXN];
    logic [7:0]  obs_addr [MAXN];
    logic [11:0] obs_gl   [MAXN];

    tile_renderer #(.BOARD_X0(X0), .BOARD_Y0(Y0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank_n(blank_n), .vs(vs), .game_over(game_over),
        .boom_x(boom_x), .boom_y(boom_y), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cell_addr(cell_addr), .cell_data(cell_data),
        .indexx(indexx), .indexy(indexy), .number(number),
        .flag(flag), .mine(mine), .dead(dead), .pixel(pixel),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read board RAM
    always @(posedge Clk) cell_data <= mem[cell_addr];

    // Toy glyph ROM: any deterministic function of the glyph selection
    assign pixel = indexx[0] ^ indexy[1] ^ number[0] ^ flag ^ mine ^ dead;

    function automatic exp_t model(int x, int y, bit blk, int cx, int cy,
                                   int bx, int by, bit gom, int fc);
        exp_t e;
        logic [9:0] wx, wy;
        logic [7:0] d;
        logic [2:0] ix, iy, num;
        int lx, ly;
        bit inb, isb, isc, f, m, dd, pix, rv, bord;
        lx  = x - X0;
        ly  = y - Y0;
        inb = (lx >= 0) && (lx < 256) && (ly >= 0) && (ly < 256);
        wx  = 10'(lx);
        wy  = 10'(ly);
        e.addr = {wy[7:4], wx[7:4]};
        d   = mem[e.addr];
        rv  = d[5];
        isb = inb && (lx / 16 == bx) && (ly / 16 == by);
        isc = inb && (lx / 16 == cx) && (ly / 16 == cy);
        f   = inb && d[4] && !rv;
        m   = inb && d[3] && (rv || gom) && !d[4] && !isb;
        dd  = inb && gom && isb;
        num = (inb && rv && !d[3]) ? d[2:0] : 3'd0;
        ix  = inb ? 3'((lx % 16) / 2) : 3'd0;
        iy  = inb ? 3'((ly % 16) / 2) : 3'd0;
        pix = ix[0] ^ iy[1] ^ num[0] ^ f ^ m ^ dd;
        e.gl = {ix, iy, num, f, m, dd};
        bord = inb && ((lx % 16 == 0) || (lx % 16 == 15) || (ly % 16 == 0) || (ly % 16 == 15));
        if (!blk)                       e.rgb = 24'h000000;
        else if (!inb)                  e.rgb = 24'h404040;
        else if (isc && bord && !gom)   e.rgb = 24'hFFFF00;
        else if (pix && (f || dd))      e.rgb = 24'hFF0000;
        else if (pix && m)              e.rgb = 24'h000000;
        else if (pix && num != 0)       e.rgb = 24'h0000FF;
        else if (gom && isb)            e.rgb = ((fc % 32) >= 16) ? 24'hFF4040 : 24'hE0E0E0;
        else if (rv)                    e.rgb = 24'hE0E0E0;
        else                            e.rgb = 24'hC0C0C0;
        return e;
    endfunction

    task automatic put(int t, int x, int y, bit b, int cx, int cy, int bx, int by);
        sx[t] = x; sy[t] = y; sb[t] = b;
        scx[t] = cx; scy[t] = cy; sbx[t] = bx; sby[t] = by;
        ex[t] = model(x, y, b, cx, cy, bx, by, go, fcnt);
    endtask

    // Drive pixels 0..n-1 one per clock and capture outputs at their latency
    task automatic run_stream(int n, int rst_at);
        for (int t = 0; t < n + 3; t++) begin
            @(negedge Clk);
            if (t >= 1 && t - 1 < n) obs_addr[t-1] = cell_addr;
            if (t >= 2 && t - 2 < n) obs_gl[t-2] = {indexx, indexy, number, flag, mine, dead};
            if (t >= 3) obs_rgb[t-3] = {Red, Green, Blue};
            if (t < n) begin
                DrawX = 10'(sx[t]); DrawY = 10'(sy[t]); blank_n = sb[t];
                cursor_x = 4'(scx[t]); cursor_y = 4'(scy[t]);
                boom_x = 4'(sbx[t]); boom_y = 4'(sby[t]);
            end else begin
                blank_n = 1'b0;
            end
            Reset_n = (t == rst_at) ? 1'b0 : 1'b1;
        end
        Reset_n = 1'b1;
        if (rst_at >= 0) fcnt = 0;
    endtask

    task automatic set_go(bit v);
        @(negedge Clk);
        if (v && !go) fcnt = 0;
        go = v;
        game_over = v;
        repeat (2) @(negedge Clk);
    endtask

    task automatic frame_tick();
        @(negedge Clk); vs = 1'b0;
        repeat (2) @(negedge Clk); vs = 1'b1;
        repeat (2) @(negedge Clk);
        fcnt = (fcnt + 1) % 32;
    endtask

    task automatic test_reset();
        exp_t e;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        nchk++;
        if ({Red, Green, Blue} !== 24'h0) begin nfail++; $display("FAIL reset_rgb: got %h, expected 000000", {Red, Green, Blue}); end
        nchk++;
        if (cell_addr !== 8'h0) begin nfail++; $display("FAIL reset_addr: got %h, expected 00", cell_addr); end
        nchk++;
        if ({indexx, indexy, number, flag, mine, dead} !== 12'h0) begin nfail++; $display("FAIL reset_glyph: got %h, expected 000", {indexx, indexy, number, flag, mine, dead}); end
        mem[8'h23] = 8'h10;
        e = model(X0 + 52, Y0 + 38, 1'b1, 15, 15, 15, 15, 1'b0, 0);
        Reset_n = 1'b1;
        DrawX = 10'(X0 + 52); DrawY = 10'(Y0 + 38); blank_n = 1'b1;
        cursor_x = 4'd15; cursor_y = 4'd15; boom_x = 4'd15; boom_y = 4'd15;
        @(negedge Clk);
        nchk++;
        if ({Red, Green, Blue} !== 24'h0) begin nfail++; $display("FAIL rel1_rgb: got %h, expected 000000", {Red, Green, Blue}); end
        nchk++;
        if ({indexx, indexy, number, flag, mine, dead} !== 12'h0) begin nfail++; $display("FAIL rel1_glyph: got %h, expected 000", {indexx, indexy, number, flag, mine, dead}); end
        @(negedge Clk);
        nchk++;
        if ({Red, Green, Blue} !== 24'h0) begin nfail++; $display("FAIL rel2_rgb: got %h, expected 000000", {Red, Green, Blue}); end
        nchk++;
        if ({indexx, indexy, number, flag, mine, dead} !== e.gl) begin nfail++; $display("FAIL rel2_glyph: got %h, expected %h", {indexx, indexy, number, flag, mine, dead}, e.gl); end
        @(negedge Clk);
        nchk++;
        if ({Red, Green, Blue} !== e.rgb) begin nfail++; $display("FAIL rel3_rgb: got %h, expected %h", {Red, Green, Blue}, e.rgb); end
        blank_n = 1'b0;
    endtask

    task automatic test_number();
        mem[8'h01] = 8'h21;
        put(0, X0 + 17, Y0 + 3, 1'b1, 9, 9, 9, 9);
        put(1, X0 + 18, Y0 + 5, 1'b1, 9, 9, 9, 9);
        run_stream(2, -1);
        nchk++;
        if (obs_addr[0] !== 8'h01) begin nfail++; $display("FAIL num_addr: got %h, expected 01", obs_addr[0]); end
        nchk++;
        if (obs_gl[0][11:3] !== {3'd0, 3'd1, 3'd1}) begin nfail++; $display("FAIL num_index: got %h, expected 009", obs_gl[0][11:3]); end
        nchk++;
        if (obs_rgb[0] !== 24'hE0E0E0 && obs_rgb[0] !== 24'h0000FF) begin nfail++; $display("FAIL num_colour_set: got %h", obs_rgb[0]); end
        for (int t = 0; t < 2; t++) begin
            nchk++;
            if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL num_rgb[%0d]: got %h, expected %h", t, obs_rgb[t], ex[t].rgb); end
            nchk++;
            if (obs_gl[t] !== ex[t].gl) begin nfail++; $display("FAIL num_glyph[%0d]: got %h, expected %h", t, obs_gl[t], ex[t].gl); end
        end
    endtask

    task automatic test_edges();
        put(0, X0 - 1,   Y0 + 5,   1'b1, 0, 0, 9, 9);
        put(1, X0 + 256, Y0 + 5,   1'b1, 0, 0, 9, 9);
        put(2, X0 + 5,   Y0 - 1,   1'b1, 0, 0, 9, 9);
        put(3, X0 + 5,   Y0 + 256, 1'b1, 0, 0, 9, 9);
        put(4, X0,       Y0,       1'b1, 1, 1, 9, 9);
        put(5, X0 + 255, Y0 + 255, 1'b1, 0, 0, 9, 9);
        put(6, X0 + 40,  Y0 + 40,  1'b0, 0, 0, 9, 9);
        put(7, 0,        0,        1'b1, 0, 0, 9, 9);
        run_stream(8, -1);
        for (int t = 0; t < 4; t++) begin
            nchk++;
            if (obs_rgb[t] !== 24'h404040) begin nfail++; $display("FAIL edge_out_rgb[%0d]: got %h, expected 404040", t, obs_rgb[t]); end
            nchk++;
            if (obs_gl[t] !== 12'h0) begin nfail++; $display("FAIL edge_out_glyph[%0d]: got %h, expected 000", t, obs_gl[t]); end
        end
        nchk++;
        if (obs_rgb[6] !== 24'h000000) begin nfail++; $display("FAIL edge_blank: got %h, expected 000000", obs_rgb[6]); end
        for (int t = 0; t < 8; t++) begin
            nchk++;
            if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL edge_rgb[%0d]: got %h, expected %h", t, obs_rgb[t], ex[t].rgb); end
            nchk++;
            if (obs_addr[t] !== ex[t].addr) begin nfail++; $display("FAIL edge_addr[%0d]: got %h, expected %h", t, obs_addr[t], ex[t].addr); end
        end
    endtask

    task automatic test_flag_mine();
        set_go(1'b1);
        mem[8'h12] = 8'h18;
        mem[8'h34] = 8'h08;
        put(0, X0 + 2*16 + 6, Y0 + 1*16 + 6, 1'b1, 0, 0, 15, 15);
        put(1, X0 + 4*16 + 6, Y0 + 3*16 + 6, 1'b1, 0, 0, 15, 15);
        run_stream(2, -1);
        nchk++;
        if (obs_gl[0][2:1] !== 2'b10) begin nfail++; $display("FAIL fm_flagged {flag,mine}: got %b, expected 10", obs_gl[0][2:1]); end
        nchk++;
        if (obs_gl[1][2:1] !== 2'b01) begin nfail++; $display("FAIL fm_mine {flag,mine}: got %b, expected 01", obs_gl[1][2:1]); end
        for (int t = 0; t < 2; t++) begin
            nchk++;
            if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL fm_rgb[%0d]: got %h, expected %h", t, obs_rgb[t], ex[t].rgb); end
        end
        set_go(1'b0);
    endtask

    task automatic test_dead_blink();
        logic [23:0] want;
        set_go(1'b0);
        mem[8'h53] = 8'h28;
        set_go(1'b1);
        for (int f = 0; f < 34; f++) begin
            put(0, X0 + 48 + 2, Y0 + 80 + 0, 1'b1, 0, 0, 3, 5);
            put(1, X0 + 48 + 8, Y0 + 80 + 8, 1'b1, 0, 0, 3, 5);
            put(2, X0 + 48 + 5, Y0 + 80 + 9, 1'b1, 0, 0, 3, 5);
            run_stream(3, -1);
            want = ((f % 32) >= 16) ? 24'hFF4040 : 24'hE0E0E0;
            nchk++;
            if (obs_rgb[0] !== want) begin nfail++; $display("FAIL blink_bg[f%0d]: got %h, expected %h", f, obs_rgb[0], want); end
            nchk++;
            if (obs_gl[0][1:0] !== 2'b01) begin nfail++; $display("FAIL blink_dead {mine,dead}[f%0d]: got %b, expected 01", f, obs_gl[0][1:0]); end
            for (int t = 1; t < 3; t++) begin
                nchk++;
                if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL blink_rgb[f%0d,%0d]: got %h, expected %h", f, t, obs_rgb[t], ex[t].rgb); end
            end
            frame_tick();
        end
        set_go(1'b0);
    endtask

    task automatic test_cursor();
        mem[8'h00] = 8'h20;
        for (int g = 0; g < 2; g++) begin
            set_go(g[0]);
            put(0, X0 + 0,  Y0 + 7,  1'b1, 0, 0, 9, 9);
            put(1, X0 + 15, Y0 + 15, 1'b1, 0, 0, 9, 9);
            put(2, X0 + 7,  Y0 + 7,  1'b1, 0, 0, 9, 9);
            put(3, X0 + 16, Y0 + 0,  1'b1, 0, 0, 9, 9);
            run_stream(4, -1);
            for (int t = 0; t < 4; t++) begin
                nchk++;
                if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL cur_rgb[go%0d,%0d]: got %h, expected %h", g, t, obs_rgb[t], ex[t].rgb); end
            end
            if (g == 0) begin
                nchk++;
                if (obs_rgb[0] !== 24'hFFFF00 || obs_rgb[1] !== 24'hFFFF00) begin nfail++; $display("FAIL cur_yellow: got %h %h, expected FFFF00", obs_rgb[0], obs_rgb[1]); end
            end
            nchk++;
            if (obs_rgb[2] === 24'hFFFF00 || (g == 1 && obs_rgb[0] === 24'hFFFF00)) begin nfail++; $display("FAIL cur_not_yellow[go%0d]: got %h %h, expected non-yellow", g, obs_rgb[0], obs_rgb[2]); end
        end
        set_go(1'b0);
    endtask

    task automatic test_random();
        int x, y, cx, cy, bx, by, n;
        n = 200;
        for (int g = 0; g < 2; g++) begin
            set_go(g[0]);
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            for (int t = 0; t < n; t++) begin
                x = X0 - 8 + int'($urandom_range(0, 271));
                y = Y0 - 8 + int'($urandom_range(0, 271));
                cx = int'($urandom_range(0, 15)); cy = int'($urandom_range(0, 15));
                bx = int'($urandom_range(0, 15)); by = int'($urandom_range(0, 15));
                if (x >= X0 && y >= Y0 && $urandom_range(0, 1) == 1) begin cx = (x - X0) % 256 / 16; cy = (y - Y0) % 256 / 16; end
                if (x >= X0 && y >= Y0 && $urandom_range(0, 1) == 1) begin bx = (x - X0) % 256 / 16; by = (y - Y0) % 256 / 16; end
                put(t, x, y, $urandom_range(0, 7) != 0, cx, cy, bx, by);
            end
            run_stream(n, -1);
            for (int t = 0; t < n; t++) begin
                nchk++;
                if (obs_addr[t] !== ex[t].addr) begin nfail++; $display("FAIL rnd_addr[go%0d,%0d]: got %h, expected %h", g, t, obs_addr[t], ex[t].addr); end
                nchk++;
                if (obs_gl[t] !== ex[t].gl) begin nfail++; $display("FAIL rnd_glyph[go%0d,%0d]: got %h, expected %h", g, t, obs_gl[t], ex[t].gl); end
                nchk++;
                if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL rnd_rgb[go%0d,%0d]: got %h, expected %h", g, t, obs_rgb[t], ex[t].rgb); end
            end
        end
        set_go(1'b0);
    endtask

    task automatic test_back_to_back_reset();
        int n, r;
        n = 24;
        r = 10;
        for (int t = 0; t < n; t++)
            put(t, X0 + int'($urandom_range(0, 255)), Y0 + int'($urandom_range(0, 255)), 1'b1,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 9, 9);
        for (int t = r - 2; t <= r; t++) ex[t].rgb = 24'h0;
        for (int t = r - 1; t <= r; t++) ex[t].gl = 12'h0;
        ex[r].addr = 8'h0;
        run_stream(n, r);
        for (int t = 0; t < n; t++) begin
            nchk++;
            if (obs_rgb[t] !== ex[t].rgb) begin nfail++; $display("FAIL mrst_rgb[%0d]: got %h, expected %h", t, obs_rgb[t], ex[t].rgb); end
            nchk++;
            if (obs_gl[t] !== ex[t].gl) begin nfail++; $display("FAIL mrst_glyph[%0d]: got %h, expected %h", t, obs_gl[t], ex[t].gl); end
            nchk++;
            if (obs_addr[t] !== ex[t].addr) begin nfail++; $display("FAIL mrst_addr[%0d]: got %h, expected %h", t, obs_addr[t], ex[t].addr); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Reset_n = 1'b0; blank_n = 1'b0; DrawX = '0; DrawY = '0;
        vs = 1'b1; game_over = 1'b0;
        boom_x = '0; boom_y = '0; cursor_x = '0; cursor_y = '0;
        test_reset();
        test_number();
        test_edges();
        test_flag_mine();
        test_dead_blink();
        test_cursor();
        test_random();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
